// File: rtl/dm_lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg -- shared types and helpers for the dm_lsu load/store unit.
//   size_e  : request size encoding (byte / half / word / reserved)
//   state_e : LSU control FSM states
//   LANES   : byte lanes per data-memory word
//   req_is_err() : misalignment / illegal-size decode for a new request
// Optional feature macro: LSU_SUBWORD_EN (byte and halfword accesses).
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  localparam int unsigned LANES = 4;

  // A request is rejected when its size is not supported in this build or
  // when the byte address is not naturally aligned to that size.
  function automatic logic req_is_err(input size_e sz, input logic [1:0] lo);
    logic err;
    case (sz)
`ifdef LSU_SUBWORD_EN
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = lo[0];
`else
      SZ_BYTE: err = 1'b1;
      SZ_HALF: err = 1'b1;
`endif
      SZ_WORD: err = (lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// -----------------------------------------------------------------------------
// dm_lsu_if -- request/response handshake between the execute stage and the
// load/store unit.
//   req_*  : valid/ready request channel (write, size, unsigned, addr, wdata)
//   resp_* : valid/ready response channel (rdata, err)
// Modports: master = execute stage side, slave = LSU side.
// -----------------------------------------------------------------------------
interface dm_lsu_if #(
  parameter int ADSize = 16,
  parameter int DASize = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADSize+1:0] req_addr;
  logic [DASize-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DASize-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align -- purely combinational lane logic for sub-word accesses.
//   rd_word     in  : word read from data memory
//   lane        in  : byte address bits [1:0]
//   size        in  : access size
//   is_unsigned in  : zero-extend loads instead of sign-extend
//   wdata       in  : right-aligned store data
//   load_data   out : extracted and extended load result
//   merged      out : rd_word with only the addressed lane replaced
// Lanes are little-endian: byte k occupies bits [8k+7:8k].
// -----------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        ext_s;

  // Select the addressed lanes out of the read word.
  always_comb begin
    byte_s = rd_word[{lane, 3'b000} +: 8];
    half_s = lane[1] ? rd_word[31:16] : rd_word[15:0];
  end

  // Extend loads and splice store data into the read word.
  always_comb begin
    load_data = rd_word;
    merged    = rd_word;
    ext_s     = 1'b0;
    case (size)
      SZ_BYTE: begin
        ext_s     = ~is_unsigned & byte_s[7];
        load_data = {{24{ext_s}}, byte_s};
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ext_s     = ~is_unsigned & half_s[15];
        load_data = {{16{ext_s}}, half_s};
        if (lane[1]) begin
          merged[31:16] = wdata[15:0];
        end else begin
          merged[15:0] = wdata[15:0];
        end
      end
      SZ_WORD: begin
        load_data = rd_word;
        merged    = wdata;
      end
      default: begin
        load_data = 32'h0000_0000;
        merged    = rd_word;
      end
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// -----------------------------------------------------------------------------
// dm_lsu -- load/store unit in front of the 64Kx32 data memory.
//   clk, rst (sync, active-high)
//   bus        : dm_lsu_if.slave request/response handshake
//   DM_enable  : data-memory access strobe (one cycle per access)
//   DM_write   : data-memory write select
//   DM_address : word address (byte address bits [ADSize+1:2])
//   DM_in      : data-memory write data
//   DM_out     : data-memory read data, valid after the negedge of a read
// Sub-word stores are read-modify-write (RD then WR). All DM_* outputs decode
// from registered state and latched request fields only.
// Optional feature macro: LSU_SUBWORD_EN enables byte/halfword accesses;
// without it only word requests are legal.
// -----------------------------------------------------------------------------
module dm_lsu
  import lsu_pkg::*;
#(
  parameter int ADSize = 16,
  parameter int DASize = 32
) (
  input  logic              clk,
  input  logic              rst,
  dm_lsu_if.slave           bus,
  output logic              DM_enable,
  output logic              DM_write,
  output logic [ADSize-1:0] DM_address,
  output logic [DASize-1:0] DM_in,
  input  logic [DASize-1:0] DM_out
);

  state_e            state_q,  state_d;
  logic [ADSize-1:0] waddr_q,  waddr_d;
  logic              write_q,  write_d;
  logic [DASize-1:0] wdata_q,  wdata_d;
  logic [DASize-1:0] rdata_q,  rdata_d;
  logic              err_q,    err_d;
  logic [DASize-1:0] load_data_s;
  logic [DASize-1:0] merged_s;
  size_e             req_size_s;

  assign req_size_s = size_e'(bus.req_size);

`ifdef LSU_SUBWORD_EN
  size_e             size_q,   size_d;
  logic [1:0]        lane_q,   lane_d;
  logic              uns_q,    uns_d;

  lsu_lane_align u_align (
    .rd_word     (DM_out),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data_s),
    .merged      (merged_s)
  );

  // Sub-word request fields, only needed by the lane logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      size_q <= SZ_BYTE;
      lane_q <= 2'b00;
      uns_q  <= 1'b0;
    end else begin
      size_q <= size_d;
      lane_q <= lane_d;
      uns_q  <= uns_d;
    end
  end
`else
  assign load_data_s = DM_out;
  assign merged_s    = wdata_q;
`endif

  // State and latched request/response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      waddr_q <= {ADSize{1'b0}};
      write_q <= 1'b0;
      wdata_q <= {DASize{1'b0}};
      rdata_q <= {DASize{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and data-path update.
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef LSU_SUBWORD_EN
    size_d  = size_q;
    lane_d  = lane_q;
    uns_d   = uns_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          waddr_d = bus.req_addr[ADSize+1:2];
          write_d = bus.req_write;
          wdata_d = bus.req_wdata;
          rdata_d = {DASize{1'b0}};
          err_d   = 1'b0;
`ifdef LSU_SUBWORD_EN
          size_d  = req_size_s;
          lane_d  = bus.req_addr[1:0];
          uns_d   = bus.req_unsigned;
`endif
          if (req_is_err(req_size_s, bus.req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (bus.req_write && (req_size_s == SZ_WORD)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        // Only loads and sub-word stores reach RD.
        if (write_q) begin
          wdata_d = merged_s;
          state_d = WR;
        end else begin
          rdata_d = load_data_s;
          state_d = RESP;
        end
      end
      WR: begin
        state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from registered state; rst masks any in-flight access.
  always_comb begin
    DM_enable      = 1'b0;
    DM_write       = 1'b0;
    DM_in          = {DASize{1'b0}};
    DM_address     = waddr_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    case (state_q)
      IDLE: begin
        bus.req_ready = ~rst;
      end
      RD: begin
        DM_enable = ~rst;
      end
      WR: begin
        DM_enable = ~rst;
        DM_write  = ~rst;
        DM_in     = wdata_q;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
      end
      default: begin
        DM_enable = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/dm_lsu.md
# dm_lsu

Load/store unit sitting directly upstream of the 64Kx32 data memory. It converts byte-addressed byte/halfword/word load and store requests from the execute stage into word-wide data-memory accesses. Sub-word stores use read-modify-write, and sub-word loads are sign- or zero-extended. It owns the data memory's enable, write, address and write-data inputs, consumes its read data, and returns one response per request over a valid/ready handshake.

## Interface
- ADSize, 16, word-address width of the data memory; the byte address is ADSize+2 bits.
- DASize, 32, data width. Fixed at 32; the lane logic assumes 4 bytes.
- clk  in  1  single clock. The LSU runs on posedge; the data memory samples on negedge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_unsigned  in  1  zero-extend on load; ignored for words and stores.
- req_addr  in  ADSize+2  byte address.
- req_wdata  in  DASize  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when high with resp_valid.
- resp_rdata  out  DASize  load result. 0 for stores and errors.
- resp_err  out  1  misaligned or reserved size.
- DM_enable  out  1  data-memory access strobe.
- DM_write  out  1  data-memory write select.
- DM_address  out  ADSize  word address, req_addr[ADSize+1:2].
- DM_in  out  DASize  data-memory write data.
- DM_out  in  DASize  data-memory read data, valid after the negedge of a read cycle.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE
  - req_ready=1 and no memory access.
  - On accept, latch addr, size, write, unsigned and wdata.
  - Error (size 11, half with addr[0]=1, word with addr[1:0]!=0): go to RESP with err=1 and no memory access.
  - Word store: go to WR. Any load or sub-word store: go to RD.
- RD: DM_enable=1, DM_write=0. At the cycle-ending posedge, capture DM_out. A load goes to RESP; a sub-word store goes to WR with merged data.
- WR: DM_enable=1, DM_write=1, DM_in = wdata for a word store, merged word for a sub-word store. Then go to RESP.
- RESP: resp_valid=1 with rdata and err held stable until resp_ready; then go to IDLE.
- One request outstanding; req_ready=0 outside IDLE.
- Lanes are little-endian; byte k is bits [8k+7:8k].
- Byte lane is addr[1:0]. Half lane is addr[1] (bits [15:0] or [31:16]).
- Loads: extract the lane and sign-extend from bit 7 or 15, or zero-extend if req_unsigned.
- Store merge: replace only the addressed lane with wdata[7:0] or wdata[15:0]. All other bytes keep their read value.
- DM_* outputs are decoded from registered state and latched request fields only. There is no combinational path from req_* to DM_*.
- DM_enable is additionally gated by !rst.

## Timing
- Latency from accept edge to resp_valid:
  - Error: 1 cycle.
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
- DM_enable is high for exactly one cycle per memory operation (two for a sub-word store: RD then WR). The data memory samples mid-cycle on negedge.
- Reset values: state IDLE; req_ready=0 while rst is high and 1 after; resp_valid=0, resp_err=0, resp_rdata=0; DM_enable=0, DM_write=0, DM_address=0, DM_in=0.
- Reset mid-operation: the transaction is abandoned with no response; DM_enable=0 during the rst cycle. The data memory clears itself on the same reset.
- While waiting in RESP under back-pressure, all outputs stay stable and there is no memory activity.

## Configuration
- LSU_SUBWORD_EN defined: byte and halfword loads/stores are supported as described above.
- LSU_SUBWORD_EN undefined:
  - Only size 10 is legal; sizes 00 and 01 return resp_err=1 with no memory access.
  - The RD-to-WR merge path and the lane logic are removed.
  - A load still goes IDLE → RD → RESP.

## Structure
- Package lsu_pkg holds:
  - the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD);
  - the state enum (IDLE, RD, WR, RESP);
  - the byte-lane count constant.
- Sub-module lsu_lane_align, purely combinational, does load extraction/extension and store merge. It is instantiated only under LSU_SUBWORD_EN.

## Test plan
- Word store 0xDEADBEEF at byte address 0x10, then word load of 0x10: DM_address=4, one-cycle DM_write pulse; load resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept.
- Word 0x11223344 at 0x10, then byte store 0xA5 at 0x11: memory becomes 0x1122A544. A signed byte load at 0x11 returns 0xFFFFFFA5; an unsigned one returns 0x000000A5.
- Half store 0x8001 at 0x12 on top of the previous result: word becomes 0x8001A544. A signed half load at 0x12 returns 0xFFFF8001; an unsigned one returns 0x00008001. The store response arrives 3 cycles after accept.
- Half load at 0x13 and size-11 request: resp_err=1, resp_rdata=0, response 1 cycle after accept, DM_enable never asserted.
- resp_ready held low 5 cycles in RESP: resp_valid, resp_rdata and resp_err are stable, req_ready=0, DM_enable=0 throughout.
- rst asserted during RD of a byte store: next cycle state IDLE, resp_valid=0, DM_enable=0, no write issued; req_ready=1 the cycle after rst falls.
